keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_sync.sv | 29 ++
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// matrix width and the one-hot row selected out of reset.
package keypad_pkg;

    localparam int KEY_W = 4;

    // Row 0 is the first row driven after reset (row_drive_n = 4'b1110).
    localparam logic [KEY_W-1:0] ROW_RESET_ONEHOT = 4'b0001;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Isolate the lowest set bit of a column vector.
    function automatic logic [KEY_W-1:0] lowest_onehot(input logic [KEY_W-1:0] v);
        return v & (~v + KEY_W'(1));
    endfunction

    // True when more than one bit of the vector is set.
    function automatic logic multi_bit(input logic [KEY_W-1:0] v);
        return (v & (v - KEY_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the raw column pins; both stages clear on srst.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic meta_reg;
        logic sync_reg;

        // Shift each pin through two flops before it is used anywhere.
        always_ff @(posedge clk) begin
            if (srst) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= d[gi];
                sync_reg <= meta_reg;
            end
        end

        assign q[gi] = sync_reg;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces the
// first key found, reports it while held and debounces its release.
// Optional build macro KEYPAD_MULTIKEY_REJECT_EN: reject presses that show
// more than one column instead of taking the lowest column.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] col_n,
    output logic [KEY_W-1:0] row_drive_n,
    output logic [KEY_W-1:0] row_keys,
    output logic [KEY_W-1:0] col_keys,
    output logic             key_valid,
    output logic             key_strobe
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0]  col_sync;
    logic [KEY_W-1:0]  col_s;

    state_t            state_reg, state_next;
    logic [KEY_W-1:0]  row_reg, row_next;
    logic [SCAN_W-1:0] scan_cnt_reg, scan_cnt_next;
    logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
    logic [KEY_W-1:0]  cap_col_reg, cap_col_next;
    logic              strobe_reg, strobe_next;

    logic              cap_bit;
    logic              reject_capture;
    logic              reject_extra;

    keypad_sync #(
        .W (KEY_W)
    ) u_sync (
        .clk  (clk),
        .srst (reset),
        .d    (col_n),
        .q    (col_sync)
    );

    // Columns are pulled up, so a pressed key reads as a 0 on the pin.
    assign col_s   = ~col_sync;
    assign cap_bit = |(col_s & cap_col_reg);

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    assign reject_capture = multi_bit(col_s);
    assign reject_extra   = |(col_s & ~cap_col_reg);
`else
    assign reject_capture = 1'b0;
    assign reject_extra   = 1'b0;
`endif

    // State, row, counters, captured column and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_SCAN;
            row_reg      <= ROW_RESET_ONEHOT;
            scan_cnt_reg <= '0;
            deb_cnt_reg  <= '0;
            cap_col_reg  <= '0;
            strobe_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            scan_cnt_reg <= scan_cnt_next;
            deb_cnt_reg  <= deb_cnt_next;
            cap_col_reg  <= cap_col_next;
            strobe_reg   <= strobe_next;
        end
    end

    // Next-state logic; counters stop at their terminal value because every
    // terminal count either leaves the state or clears the counter.
    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        scan_cnt_next = scan_cnt_reg;
        deb_cnt_next  = deb_cnt_reg;
        cap_col_next  = cap_col_reg;
        strobe_next   = 1'b0;

        case (state_reg)
            ST_SCAN: begin
                if (scan_cnt_reg == SCAN_LAST) begin
                    scan_cnt_next = '0;
                    if ((col_s == '0) || reject_capture) begin
                        row_next = {row_reg[KEY_W-2:0], row_reg[KEY_W-1]};
                    end else begin
                        cap_col_next = lowest_onehot(col_s);
                        deb_cnt_next = '0;
                        state_next   = ST_DEBOUNCE;
                    end
                end else begin
                    scan_cnt_next = scan_cnt_reg + SCAN_W'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (reject_extra) begin
                    // A second column appeared: drop this row entirely.
                    state_next    = ST_SCAN;
                    row_next      = {row_reg[KEY_W-2:0], row_reg[KEY_W-1]};
                    scan_cnt_next = '0;
                    deb_cnt_next  = '0;
                end else if (!cap_bit) begin
                    // Bounce: rescan the same row from the start.
                    state_next    = ST_SCAN;
                    scan_cnt_next = '0;
                    deb_cnt_next  = '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    state_next   = ST_HELD;
                    strobe_next  = 1'b1;
                    deb_cnt_next = '0;
                end else begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
            end

            ST_HELD: begin
                if (reject_extra) begin
                    state_next    = ST_SCAN;
                    row_next      = {row_reg[KEY_W-2:0], row_reg[KEY_W-1]};
                    scan_cnt_next = '0;
                    deb_cnt_next  = '0;
                end else if (!cap_bit) begin
                    state_next   = ST_RELEASE;
                    deb_cnt_next = '0;
                end
            end

            ST_RELEASE: begin
                if (cap_bit) begin
                    // Release bounce: key still counts as held, no new strobe.
                    state_next   = ST_HELD;
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    state_next    = ST_SCAN;
                    row_next      = {row_reg[KEY_W-2:0], row_reg[KEY_W-1]};
                    scan_cnt_next = '0;
                    deb_cnt_next  = '0;
                end else begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
            end

            default: begin
                state_next = ST_SCAN;
            end
        endcase
    end

    assign row_drive_n = ~row_reg;
    assign key_valid   = (state_reg == ST_HELD) || (state_reg == ST_RELEASE);
    assign row_keys    = key_valid ? row_reg : '0;
    assign col_keys    = key_valid ? cap_col_reg : '0;
    assign key_strobe  = strobe_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
// A small keypad model pulls a column low when its key is pressed and the
// key's row is being driven.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] col_n;
    logic [3:0] row_drive_n;
    logic [3:0] row_keys;
    logic [3:0] col_keys;
    logic       key_valid;
    logic       key_strobe;

    logic [3:0] press_mask [4];

    int checks   = 0;
    int failures = 0;
    int lat;

    keypad_scanner #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .col_n       (col_n),
        .row_drive_n (row_drive_n),
        .row_keys    (row_keys),
        .col_keys    (col_keys),
        .key_valid   (key_valid),
        .key_strobe  (key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!row_drive_n[r]) col_n = col_n & ~press_mask[r];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_row_drive_n"}, {28'd0, row_drive_n}, 32'hE);
        check({tag, "_key_valid"},   {31'd0, key_valid},   32'h0);
        check({tag, "_key_strobe"},  {31'd0, key_strobe},  32'h0);
        check({tag, "_row_keys"},    {28'd0, row_keys},    32'h0);
        check({tag, "_col_keys"},    {28'd0, col_keys},    32'h0);
    endtask

    // Wait for a strobe; lat = cycles waited, or -1 when the budget expires.
    task automatic wait_strobe(input int budget, output int latency);
        latency = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (key_strobe === 1'b1) begin
                latency = c;
                break;
            end
        end
    endtask

    // Wait for key_valid to fall, checking no strobe appears meanwhile.
    task automatic wait_release(input string tag, input int budget, output int latency);
        latency = -1;
        for (int c = 1; c <= budget; c++) begin
            tick();
            check({tag, "_no_strobe"}, {31'd0, key_strobe}, 32'h0);
            if (key_valid === 1'b0) begin
                latency = c;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int r = 0; r < 4; r++) press_mask[r] = 4'b0000;

        // Reset state
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;

        // Idle scan: row 0,1,2,3 for 4 cycles each
        for (int k = 0; k < 64; k++) begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            check("idle_row_drive_n", {28'd0, row_drive_n}, {28'd0, exp_row});
            check("idle_key_strobe",  {31'd0, key_strobe},  32'h0);
            if (k < 63) tick();
        end
        tick();
        $display("idle scan: 64 cycles done");

        // Clean press on row 2, column 1
        press_mask[2] = 4'b0010;
        wait_strobe(40, lat);
        check("press_strobe_seen", {31'd0, lat > 0}, 32'h1);
        check("press_latency_max", {31'd0, lat <= 26}, 32'h1);
        check("press_row_keys",    {28'd0, row_keys},  32'h4);
        check("press_col_keys",    {28'd0, col_keys},  32'h2);
        check("press_key_valid",   {31'd0, key_valid}, 32'h1);
        $display("press r2c1: strobe after %0d cycles", lat);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("held_no_strobe", {31'd0, key_strobe}, 32'h0);
            check("held_key_valid", {31'd0, key_valid},  32'h1);
        end
        press_mask[2] = 4'b0000;
        wait_release("release1", 30, lat);
        check("release1_seen",     {31'd0, lat > 0},  32'h1);
        check("release1_debounce", {31'd0, lat >= 8}, 32'h1);
        check("release1_next_row", {28'd0, row_drive_n}, 32'h7);
        check("release1_row_keys", {28'd0, row_keys}, 32'h0);
        check("release1_col_keys", {28'd0, col_keys}, 32'h0);
        $display("release r2c1: key_valid fell after %0d cycles", lat);

        // Bouncing press on row 1, column 3
        for (int i = 0; i < 20; i++) begin
            press_mask[1] = (((i / 3) % 2) == 0) ? 4'b1000 : 4'b0000;
            tick();
            check("bounce_no_strobe", {31'd0, key_strobe}, 32'h0);
        end
        press_mask[1] = 4'b1000;
        wait_strobe(40, lat);
        check("bounce_strobe_seen", {31'd0, lat > 0},  32'h1);
        check("bounce_stable_min",  {31'd0, lat >= 8}, 32'h1);
        check("bounce_row_keys",    {28'd0, row_keys}, 32'h2);
        check("bounce_col_keys",    {28'd0, col_keys}, 32'h8);
        $display("bounced press r1c3: strobe %0d cycles after settling", lat);

        // Release bounce of 5 cycles inside RELEASE
        repeat (4) begin
            tick();
            check("held2_no_strobe", {31'd0, key_strobe}, 32'h0);
        end
        press_mask[1] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("relbounce_key_valid", {31'd0, key_valid},  32'h1);
            check("relbounce_no_strobe", {31'd0, key_strobe}, 32'h0);
        end
        press_mask[1] = 4'b1000;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("rehold_key_valid", {31'd0, key_valid},  32'h1);
            check("rehold_no_strobe", {31'd0, key_strobe}, 32'h0);
        end
        check("rehold_col_keys", {28'd0, col_keys}, 32'h8);
        press_mask[1] = 4'b0000;
        wait_release("release2", 30, lat);
        check("release2_seen",     {31'd0, lat > 0},     32'h1);
        check("release2_next_row", {28'd0, row_drive_n}, 32'hB);
        $display("release bounce r1c3: valid held, final release after %0d cycles", lat);

        // Reset pulsed during DEBOUNCE of a row 0 key
        press_mask[0] = 4'b0001;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("predeb_no_strobe", {31'd0, key_strobe}, 32'h0);
        end
        // A scanning FSM would be on row 1 by now; row 0 still driven means DEBOUNCE.
        check("predeb_row_held", {28'd0, row_drive_n}, 32'hE);
        reset = 1'b1;
        press_mask[0] = 4'b0000;
        tick();
        check_idle_outputs("rst_mid_deb");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_no_strobe", {31'd0, key_strobe}, 32'h0);
        end
        $display("reset during debounce: outputs cleared, no strobe");

        // Two columns pressed on row 0
        press_mask[0] = 4'b0011;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        check("multi_row_advanced", {28'd0, row_drive_n}, 32'hD);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("multi_no_strobe", {31'd0, key_strobe}, 32'h0);
        end
        $display("two keys row 0: rejected, scanning continued");
`else
        check("multi_row_held", {28'd0, row_drive_n}, 32'hE);
        wait_strobe(20, lat);
        check("multi_strobe_seen", {31'd0, lat > 0},  32'h1);
        check("multi_row_keys",    {28'd0, row_keys}, 32'h1);
        check("multi_col_keys",    {28'd0, col_keys}, 32'h1);
        $display("two keys row 0: lowest column accepted after %0d cycles", lat);
`endif
        press_mask[0] = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
